// File: rtl/ps2_line_filter_pkg.sv
// ps2_pkg: shared PS/2 line constants and counter sizing helper.
package ps2_pkg;
  localparam logic PS2_IDLE = 1'b1;
  localparam int PS2_CLK_CH = 0;
  localparam int PS2_DAT_CH = 1;
  function automatic int min_cnt_w(input int thresh);
    for (int w = 1; w < 31; w++) if ((1 << w) >= thresh) return w;
    return 31;
  endfunction
endpackage

// File: rtl/ps2_line_filter_if.sv
// ps2_line_filter_if: raw PS/2 lines in, filtered levels and edge strobes out.
interface ps2_line_filter_if #(parameter int CHANNELS = 2);
  logic ce;
  logic [CHANNELS-1:0] in, out, rise, fall;
  modport master(output ce, in, input out, rise, fall);
  modport slave(input ce, in, output out, rise, fall);
endinterface

// File: rtl/ps2_line_filter_ch.sv
// ps2_line_filter_ch: one-line synchroniser, run-length glitch filter and edge strobes.
module ps2_line_filter_ch
  import ps2_pkg::*;
#(
  parameter int CNT_W = 4,
  parameter int THRESH = 8,
  parameter logic RESET_VAL = PS2_IDLE
) (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall
);
  if (THRESH < 1 || CNT_W < min_cnt_w(THRESH)) begin : g_bad_thresh
    $error("ps2_line_filter_ch: THRESH %0d outside 1..2**CNT_W", THRESH);
  end
  localparam logic [CNT_W-1:0] LAST = CNT_W'(THRESH - 1);
  logic s1, s2, hit;
  logic [CNT_W-1:0] cnt;
  assign hit = (s2 != out) && ce && (cnt == LAST);
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= RESET_VAL;
      s2   <= RESET_VAL;
      out  <= RESET_VAL;
      cnt  <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= in;
      s2   <= s1;
      // a sample matching out discards any partial run, even with ce low
      cnt  <= (s2 == out || hit) ? '0 : ce ? cnt + 1'b1 : cnt;
      out  <= hit ? s2 : out;
      rise <= hit && s2;
      fall <= hit && !s2;
    end
  end
endmodule

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: independent glitch filters for the PS/2 clock and data lines.
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int CNT_W = 4,
  parameter int THRESH = 8,
  parameter logic RESET_VAL = PS2_IDLE
) (
  input logic clk,
  input logic rst,
  ps2_line_filter_if.slave bus
);
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    ps2_line_filter_ch #(
      .CNT_W(CNT_W),
      .THRESH(THRESH),
      .RESET_VAL(RESET_VAL)
    ) u_ch (
      .clk(clk),
      .rst(rst),
      .ce(bus.ce),
      .in(bus.in[i]),
      .out(bus.out[i]),
      .rise(bus.rise[i]),
      .fall(bus.fall[i])
    );
  end
endmodule

// File: tb/tb_ps2_line_filter.sv
// tb_ps2_line_filter: vector table plus event scoreboard of expected strobes.
module tb_ps2_line_filter;
  import ps2_pkg::*;
  localparam int THRESH = 8;
  typedef struct {int cyc; int ch; logic lvl;} ev_t;
  typedef struct {logic [1:0] in; int len;} vec_t;
  logic clk = 1'b0, rst = 1'b1;
  int cyc = 0, checks = 0, errors = 0;
  bit mon_on = 1'b0, model_on = 1'b1;
  ev_t q[$];
  logic [1:0] flt = 2'b11, lvl = 2'b11;
  int run [2] = '{0, 0};
  vec_t vecs [16];
  int k0;
  ps2_line_filter_if #(.CHANNELS(2)) bus();
  ps2_line_filter #(.CHANNELS(2), .CNT_W(4), .THRESH(THRESH), .RESET_VAL(PS2_IDLE)) dut (
    .clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Input-side model: a level that differs from the accepted level for THRESH
  // consecutive driven cycles produces a strobe THRESH+2 cycles after it began.
  task automatic drive(input logic [1:0] v, input logic r, input logic c);
    @(posedge clk);
    #1;
    rst = r;
    bus.ce = c;
    bus.in = v;
    if (r) begin
      flt = {2{PS2_IDLE}};
      run = '{0, 0};
    end else if (model_on) begin
      for (int ch = 0; ch < 2; ch++) begin
        if (v[ch] != flt[ch]) begin
          run[ch]++;
          if (run[ch] == THRESH) begin
            q.push_back('{cyc + 3, ch, v[ch]});
            flt[ch] = v[ch];
            run[ch] = 0;
          end
        end else run[ch] = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      while (q.size() != 0 && q[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL missed_strobe cyc=%0d: expected ch%0d -> %0b at cyc %0d, no strobe observed", cyc, q[0].ch, q[0].lvl, q[0].cyc);
        q.delete(0);
      end
      for (int c = 0; c < 2; c++) begin
        checks++;
        if (bus.rise[c] && bus.fall[c]) begin
          errors++;
          $display("FAIL rise_and_fall cyc=%0d ch%0d: both strobes high", cyc, c);
        end
        if (bus.rise[c] || bus.fall[c]) begin
          checks++;
          if (q.size() != 0 && q[0].cyc == cyc && q[0].ch == c) begin
            if (q[0].lvl != bus.rise[c]) begin
              errors++;
              $display("FAIL strobe_kind cyc=%0d ch%0d: got rise=%0b fall=%0b, required level %0b", cyc, c, bus.rise[c], bus.fall[c], q[0].lvl);
            end
            lvl[c] = q[0].lvl;
            q.delete(0);
          end else begin
            errors++;
            $display("FAIL unexpected_strobe cyc=%0d ch%0d: got rise=%0b fall=%0b, required none", cyc, c, bus.rise[c], bus.fall[c]);
          end
        end
        checks++;
        if (bus.out[c] !== lvl[c]) begin
          errors++;
          $display("FAIL out_level cyc=%0d ch%0d: got %0b, required %0b", cyc, c, bus.out[c], lvl[c]);
        end
      end
    end
  end

  initial begin
    vecs = '{'{2'b11, 12}, '{2'b10, 6}, '{2'b11, 10}, '{2'b10, 8}, '{2'b11, 12},
             '{2'b10, 7}, '{2'b11, 10}, '{2'b01, 12}, '{2'b11, 12}, '{2'b10, 5},
             '{2'b11, 1}, '{2'b10, 5}, '{2'b11, 10}, '{2'b00, 12}, '{2'b11, 12},
             '{2'b11, 4}};
    bus.ce = 1'b1;
    bus.in = 2'b00;
    // reset held with lines low, then released: both channels fall 9 edges later
    drive(2'b00, 1'b1, 1'b1);
    mon_on = 1'b1;
    drive(2'b00, 1'b1, 1'b1);
    drive(2'b00, 1'b1, 1'b1);
    for (int i = 0; i < 12; i++) drive(2'b00, 1'b0, 1'b1);
    foreach (vecs[i]) for (int j = 0; j < vecs[i].len; j++) drive(vecs[i].in, 1'b0, 1'b1);
    // ce every 4th clk: 8 qualifying samples land 32 edges after the change
    model_on = 1'b0;
    drive(2'b10, 1'b0, 1'b0);
    k0 = cyc;
    q.push_back('{k0 + 32, PS2_CLK_CH, 1'b0});
    for (int i = 1; i < 40; i++) drive(2'b10, 1'b0, (i % 4) == 3);
    // 5 counts, ce held low, a brief return to out clears the run, then 8 fresh counts
    drive(2'b11, 1'b0, 1'b0);
    k0 = cyc;
    q.push_back('{k0 + 64, PS2_CLK_CH, 1'b1});
    for (int j = 1; j < 70; j++)
      drive((j == 30 || j == 31) ? 2'b10 : 2'b11, 1'b0, j < 20 ? (j % 4) == 3 : j < 32 ? 1'b0 : (j % 4) == 3);
    model_on = 1'b1;
    run = '{0, 0};
    for (int i = 0; i < 4; i++) drive(2'b11, 1'b0, 1'b1);
    // reset while channel 0 run is at 5: no strobe, then full latency after release
    for (int i = 0; i < 7; i++) drive(2'b10, 1'b0, 1'b1);
    drive(2'b10, 1'b1, 1'b1);
    for (int i = 0; i < 14; i++) drive(2'b10, 1'b0, 1'b1);
    for (int i = 0; i < 14; i++) drive({1'b1, 1'b1}, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) drive(2'b11, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: got %0d outstanding, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ps2_line_filter.md
# ps2_line_filter

Multi-channel glitch filter and edge detector for the asynchronous PS/2 clock and data lines. It sits between the keyboard pins and the PS/2 frame receiver. Each channel has a two-flop synchroniser, a per-channel run-length counter with an optional sample-enable, and a filtered level output. A filtered change is accepted only after the new level has persisted for THRESH consecutive samples. One-cycle rise and fall strobes are emitted on each accepted change.

## Interface
- CHANNELS, 2: number of independent lines (PS/2 clock and data by default).
- CNT_W, 4: width of each run-length counter.
- THRESH, 8: consecutive differing samples required to accept a change; legal range 1..2**CNT_W.
- RESET_VAL, 1: reset level of every filtered output (PS/2 lines idle high).
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset, synchronous and active-high.
- ce  in  1  sample enable; tie high to count every clk.
- in  in  CHANNELS  raw asynchronous line inputs.
- out  out  CHANNELS  filtered, synchronised levels.
- rise  out  CHANNELS  one-cycle strobe when out[i] goes 0->1.
- fall  out  CHANNELS  one-cycle strobe when out[i] goes 1->0.

## Operation
- Synchroniser per channel: s1 <= in[i], s2 <= s1, every clk, independent of ce.
- Counter cnt[i] (CNT_W bits) per channel. Per-edge priority is as follows:
  1. rst: out <= RESET_VAL, s1/s2 <= RESET_VAL, cnt <= 0, rise/fall <= 0.
  2. If s2 == out: cnt <= 0. A partial run is discarded immediately, regardless of ce.
  3. Else if ce == 0: cnt holds.
  4. Else if cnt == THRESH-1: out <= s2, cnt <= 0, and the matching strobe is asserted for the next cycle.
  5. Else: cnt <= cnt + 1.
- Arithmetic: the compare uses THRESH-1 truncated to CNT_W, so the counter never wraps. An elaboration-time error is raised for THRESH outside 1..2**CNT_W.
- rise/fall are registered. They are high for exactly one clk after the edge that updates out, and rise and fall are never both high on one channel.
- Channels are fully independent, so simultaneous changes on several channels each produce their own strobe in the same cycle.
- The block has no state machine beyond the per-channel accept/hold counter.

## Timing
- With ce=1, suppose a new level is first captured into s1 at edge E0 and stays stable. Then out changes at edge E0+THRESH+1, and the strobe is high during the cycle after that edge.
- THRESH=1 gives the minimum latency: out changes at E0+2.
- A pulse shorter than THRESH samples at s2 is rejected. out and the strobes stay unchanged and cnt returns to 0.
- With ce gated, latency is THRESH ce-high cycles after s2 first differs, plus one clk.
- Reset asserted mid-count drops the run. out returns to RESET_VAL on the next edge, and no strobe is generated by the reset itself.
- After reset is released with in equal to RESET_VAL, no strobe appears.
- If in differs from RESET_VAL at release, the change is accepted after the normal latency and produces a normal strobe.

## Structure
- Shared package ps2_pkg holds:
  - PS2_IDLE = 1'b1;
  - the channel index constants PS2_CLK_CH = 0 and PS2_DAT_CH = 1;
  - a helper function computing the minimum CNT_W for a given THRESH.
- Sub-module ps2_line_filter_ch implements one channel (synchroniser, counter, out, rise, fall), parametrised by CNT_W, THRESH and RESET_VAL.
- The top level generates CHANNELS instances and shares clk, rst and ce across them.

## Test plan
All scenarios use CHANNELS=2, CNT_W=4, THRESH=8, RESET_VAL=1, and ce=1 unless stated.
- Reset: hold rst 3 cycles with in=2'b00 -> out=2'b11 and rise=fall=0 during and one cycle after rst. Then in=00 stable -> fall=2'b11 for one cycle, and out=00 exactly 9 edges after the first s1 capture of 00.
- Glitch reject: with out[0]=1, drive in[0]=0 for 6 clk then back to 1 -> out[0] stays 1, fall[0] never asserts, cnt[0] returns to 0.
- Threshold boundary: with out[0]=1, drive in[0]=0 for exactly 8 clk then back to 1.
  - out[0] falls at E0+9 and fall[0] pulses once.
  - The return to 1 held for 8 clk gives one rise[0] pulse.
  - A 7-clk low pulse gives no response.
- Independent channels: toggle in[0] and in[1] in the same cycle -> rise[0] and rise[1] high in the same single cycle; a change on channel 1 alone never affects cnt[0].
- Sample enable: ce high every 4th clk, in[0] 1->0 -> out[0] changes after 8 ce-high cycles (~32 clk). Deasserting ce mid-run holds cnt, and returning in[0] to 1 during the hold clears cnt.
- Reset mid-operation: assert rst when cnt[0]=5 -> next edge out[0]=1 and cnt[0]=0 with no strobe. After release, a stable low input is accepted with the full 9-edge latency.
